// File: rtl/nic_pkg.sv
// Shared NIC definitions: packet geometry, field positions and the tx FSM encoding.
package nic_pkg;

  localparam int DATA_SIZE = 64;
  localparam int VC_BIT    = 63;

  // Header field positions shared by every NIC block that parses packets.
  localparam int DIR_BIT   = 62;
  localparam int HOP_MSB   = 61;
  localparam int HOP_LSB   = 58;
  localparam int SRC_MSB   = 57;
  localparam int SRC_LSB   = 50;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/nic_tx_ctrl_if.sv
// Buffer-side and router-side signals of the NIC transmit controller.
//
// Handshakes: buf_re is a read strobe. It is asserted only when buf_status=1 and
// the buffer entry is consumed at that same clock edge. net_so is a send strobe.
// It is asserted only when net_ro=1 and the polarity phase matches, and the router
// takes net_do at that same edge. Neither strobe is ever raised without its transfer.
interface nic_tx_ctrl_if #(
  parameter int DATA_SIZE = nic_pkg::DATA_SIZE
);

  logic                 buf_status;
  logic [DATA_SIZE-1:0] buf_data;
  logic                 buf_re;
  logic                 net_ro;
  logic                 net_polarity;
  logic                 net_so;
  logic [DATA_SIZE-1:0] net_do;

  modport master (
    input  buf_status, buf_data, net_ro, net_polarity,
    output buf_re, net_so, net_do
  );

  modport slave (
    output buf_status, buf_data, net_ro, net_polarity,
    input  buf_re, net_so, net_do
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the NIC statistics blocks.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/nic_tx_ctrl.sv
// NIC transmit injection controller: drains the single-entry buffer into a holding
// register and injects it into the router when ready and in the permitted VC phase.
module nic_tx_ctrl #(
  parameter int DATA_SIZE = nic_pkg::DATA_SIZE,
  parameter int VC_BIT    = nic_pkg::VC_BIT,
  parameter int CNT_W     = 16,
  parameter int STALL_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  nic_tx_ctrl_if.master      bus,
  output logic [CNT_W-1:0]   tx_count,
  output logic [STALL_W-1:0] stall_cnt,
  output nic_pkg::tx_state_t state
);

  import nic_pkg::*;

  tx_state_t            state_q;
  tx_state_t            state_d;
  logic [DATA_SIZE-1:0] hold_q;
  logic [CNT_W-1:0]     tx_count_q;
  logic                 fire;
  logic                 load;
  logic                 stall_clr;
  logic                 stall_inc;

  // Strobes are gated by reset so nothing is read or sent while reset is held.
  always_comb begin
    fire      = 1'b0;
    load      = 1'b0;
    state_d   = state_q;
    stall_clr = 1'b0;
    stall_inc = 1'b0;

    fire = reset && (state_q == ST_WAIT) && bus.net_ro &&
           (hold_q[VC_BIT] != bus.net_polarity);
    load = reset && bus.buf_status && ((state_q == ST_IDLE) || fire);

    if (load) begin
      state_d = ST_WAIT;
    end else if (fire) begin
      state_d = ST_IDLE;
    end

    stall_clr = fire || (load && (state_q == ST_IDLE));
    stall_inc = (state_q == ST_WAIT) && !fire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      tx_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        hold_q <= bus.buf_data;
      end
      if (fire) begin
        tx_count_q <= tx_count_q + 1'b1;
      end
    end
  end

  sat_counter #(
    .WIDTH (STALL_W)
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (stall_clr),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  assign bus.buf_re = load;
  assign bus.net_so = fire;
  assign bus.net_do = hold_q;
  assign tx_count   = tx_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_nic_tx_ctrl.sv
// Bench for nic_tx_ctrl: directed scenarios plus randomized traffic against a packet-level model.
module tb_nic_tx_ctrl;

  import nic_pkg::*;

  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  nic_tx_ctrl_if #(.DATA_SIZE(DW)) bus ();
  nic_tx_ctrl_if #(.DATA_SIZE(DW)) bus_s ();

  logic [15:0] tx_count;
  logic [7:0]  stall_cnt;
  tx_state_t   state;
  logic [3:0]  tx_count_s;
  logic [7:0]  stall_cnt_s;
  tx_state_t   state_s;

  nic_tx_ctrl #(.DATA_SIZE(DW), .VC_BIT(VC_BIT), .CNT_W(16), .STALL_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .tx_count  (tx_count),
    .stall_cnt (stall_cnt),
    .state     (state)
  );

  // Narrow-counter twin sharing the same stimulus, so counter wrap is reachable quickly.
  nic_tx_ctrl #(.DATA_SIZE(DW), .VC_BIT(VC_BIT), .CNT_W(4), .STALL_W(8)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_s),
    .tx_count  (tx_count_s),
    .stall_cnt (stall_cnt_s),
    .state     (state_s)
  );

  assign bus_s.buf_status   = bus.buf_status;
  assign bus_s.buf_data     = bus.buf_data;
  assign bus_s.net_ro       = bus.net_ro;
  assign bus_s.net_polarity = bus.net_polarity;

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_hold = '0;
  int unsigned   n_tx      = 0;
  int unsigned   n_stall   = 0;
  logic          phase     = 1'b0;
  int            errors    = 0;
  int            checks    = 0;
  logic          so, re;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_hold = '0;
    n_tx      = 0;
    n_stall   = 0;
  endtask

  // ---------------- driver: one clock cycle, entered and left at negedge ----------------
  task automatic step(input logic bs, input logic [DW-1:0] d, input logic ro,
                      output logic so_obs, output logic re_obs);
    logic          full;
    logic          fire_e;
    logic          re_e;
    logic [DW-1:0] pkt;
    bus.buf_status   = bs;
    bus.buf_data     = d;
    bus.net_ro       = ro;
    bus.net_polarity = phase;
    #1;
    full   = (exp_q.size() != 0);
    fire_e = 1'b0;
    if (full) fire_e = ro && (exp_q[0][VC_BIT] != phase);
    re_e = bs && (!full || fire_e);

    chk("net_so", bus.net_so, fire_e);
    chk("buf_re", bus.buf_re, re_e);
    chk("net_do", bus.net_do, last_hold);
    chk("tx_count", tx_count, n_tx[15:0]);
    chk("tx_count_w4", tx_count_s, n_tx % 16);
    chk("stall_cnt", stall_cnt, n_stall);
    chk("state", state, full ? ST_WAIT : ST_IDLE);
    so_obs = bus.net_so;
    re_obs = bus.buf_re;

    if (fire_e) begin
      pkt = exp_q.pop_front();
      chk("inject_pkt", bus.net_do, pkt);
      n_tx++;
      n_stall = 0;
    end
    if (re_e) begin
      exp_q.push_back(d);
      last_hold = d;
      if (!full) n_stall = 0;
    end else if (full && !fire_e) begin
      n_stall = (n_stall >= 255) ? 255 : n_stall + 1;
    end

    @(posedge clk);
    phase = ~phase;
    @(negedge clk);
  endtask

  task automatic align(input logic p);
    logic a, b;
    if (phase != p) step(1'b0, '0, 1'b0, a, b);
  endtask

  task automatic drain();
    logic a, b;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, a, b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          src_full;
    logic [DW-1:0] src_data;

    bus.buf_status   = 1'b0;
    bus.buf_data     = '0;
    bus.net_ro       = 1'b0;
    bus.net_polarity = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // reset values
    step(1'b0, '0, 1'b1, so, re);
    chk("rst_net_do", bus.net_do, 64'h0);

    // basic inject: vc=1 packet goes out when polarity is 0
    align(1'b0);
    step(1'b1, 64'h8000_0000_0000_0001, 1'b1, so, re);
    chk("basic_re_c0", re, 1'b1);
    chk("basic_so_c0", so, 1'b0);
    step(1'b0, '0, 1'b1, so, re);
    chk("basic_so_c1", so, 1'b0);
    step(1'b0, '0, 1'b1, so, re);
    chk("basic_so_c2", so, 1'b1);
    chk("basic_tx_count", tx_count, 16'd1);
    chk("basic_net_do", bus.net_do, 64'h8000_0000_0000_0001);

    // backpressure: 5 cycles with net_ro=0, release lands on the matching phase
    align(1'b1);
    step(1'b1, 64'h0000_0000_0000_0003, 1'b0, so, re);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, so, re);
      chk("bp_so_low", so, 1'b0);
    end
    chk("bp_stall5", stall_cnt, 8'd5);
    step(1'b0, '0, 1'b1, so, re);
    chk("bp_release_so", so, 1'b1);
    chk("bp_stall_clr", stall_cnt, 8'd0);
    chk("bp_tx_count", tx_count, 16'd2);

    // back-to-back: refill during WAIT, then fire with buf_status=1
    align(1'b1);
    step(1'b1, 64'h8000_0000_0000_0005, 1'b0, so, re);
    step(1'b1, 64'h0000_0000_0000_0002, 1'b0, so, re);
    chk("b2b_no_read_wait", re, 1'b0);
    step(1'b1, 64'h0000_0000_0000_0002, 1'b1, so, re);
    chk("b2b_wrong_phase_so", so, 1'b0);
    step(1'b1, 64'h0000_0000_0000_0002, 1'b1, so, re);
    chk("b2b_fire_so", so, 1'b1);
    chk("b2b_fire_re", re, 1'b1);
    chk("b2b_next_do", bus.net_do, 64'h0000_0000_0000_0002);
    chk("b2b_next_state", state, ST_WAIT);
    step(1'b0, '0, 1'b1, so, re);
    chk("b2b_second_so", so, 1'b1);

    // asynchronous reset while a packet is held and the buffer is full
    step(1'b1, 64'h8000_0000_0000_0007, 1'b0, so, re);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_net_so", bus.net_so, 1'b0);
    chk("arst_buf_re", bus.buf_re, 1'b0);
    chk("arst_net_do", bus.net_do, 64'h0);
    chk("arst_tx_count", tx_count, 16'd0);
    chk("arst_stall", stall_cnt, 8'd0);
    chk("arst_state", state, ST_IDLE);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.net_polarity = phase;
      phase = ~phase;
      #1;
      chk("arst_hold_re", bus.buf_re, 1'b0);
    end
    @(negedge clk);
    bus.buf_status = 1'b0;
    reset = 1'b1;

    // stall counter saturation
    step(1'b1, 64'h0000_0000_0000_0009, 1'b0, so, re);
    for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b0, so, re);
    chk("sat_stall", stall_cnt, 8'hFF);
    drain();

    // randomized traffic from a buffer that holds its data until read
    src_full = 1'b0;
    src_data = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!src_full && ($urandom_range(0, 1) == 1)) begin
        src_full = 1'b1;
        src_data = {$urandom, $urandom};
      end
      step(src_full, src_full ? src_data : 64'h0, ($urandom_range(0, 3) != 0), so, re);
      if (re === 1'b1) src_full = 1'b0;
    end
    drain();

    // counter wrap on the narrow twin
    for (int i = 0; i < 40 && (n_tx % 16) != 15; i++) begin
      step(1'b1, {1'(i), 63'(i)}, 1'b1, so, re);
      drain();
    end
    chk("wrap_pre", tx_count_s, 4'hF);
    step(1'b1, 64'h8000_0000_0000_00AA, 1'b1, so, re);
    drain();
    chk("wrap_w4_zero", tx_count_s, 4'h0);
    chk("wrap_w16_total", tx_count, n_tx[15:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
